neopixel_bit_encoder: RTL
=========================

// Module: neopixel_bit_encoder
// PURPOSE
//  Stage directly downstream of the strand controller: takes 24-bit GRB pixel words over a
//  valid/ready handshake and drives the single-wire NeoPixel waveform on neo_data.
//  Each bit is a fixed-period pulse whose high time encodes 0/1, sent MSB first.
//  After the last word of a frame, holds the line low for the latch/reset interval.
// PARAMETERS
//  WORD_BITS  24    bits per pixel word (G[23:16],R[15:8],B[7:0])
//  BIT_CYC    63    clock cycles per bit slot (1.26us @ 50MHz)
//  T0H_CYC    18    high cycles for a 0 bit (0.36us)
//  T1H_CYC    35    high cycles for a 1 bit (0.70us)
//  LATCH_CYC  2500  low cycles after the frame's last bit (50us)
// PORTS
//  clock       in   1   system clock, 50MHz
//  reset       in   1   synchronous, active-high reset
//  word_data   in   24  pixel word, MSB sent first
//  word_valid  in   1   word_data/word_last valid
//  word_last   in   1   this word ends the frame
//  word_ready  out  1   encoder accepts word this cycle (accept = valid & ready)
//  neo_data    out  1   serial line to the LED strand
//  busy        out  1   high from accept until latch interval ends
//  latch_done  out  1   one-cycle pulse when latch interval completes
//  underrun    out  1   one-cycle pulse: non-last word ended with no next word available
// BEHAVIOUR
//  Clock is `clock`; reset is synchronous, active-high, named `reset`. Only clock edge used.
//  Reset values: neo_data=0, busy=0, latch_done=0, underrun=0, state=IDLE; word_ready=1 after reset.
//  States: IDLE, SEND, LATCH.
//  IDLE: word_ready=1, neo_data=0. On accept: load shift reg, bit_idx=0, cyc=0, store last -> SEND.
//  SEND: neo_data=1 while cyc < (bit ? T1H_CYC : T0H_CYC), else 0; cyc counts 0..BIT_CYC-1.
//   At cyc==BIT_CYC-1: shift left, bit_idx++. At final cycle of bit WORD_BITS-1:
//   - word not last: word_ready=1 this cycle only; if word_valid, load next word, stay SEND
//     (zero gap between words); else pulse underrun, -> LATCH.
//   - word last: word_ready=0, -> LATCH.
//  word_ready=0 in all other SEND cycles and in LATCH; word_valid then ignored.
//  LATCH: neo_data=0 for exactly LATCH_CYC cycles; last cycle -> IDLE with latch_done=1 next cycle.
//  Latency: accept on edge N -> neo_data high in cycle N+1; one word = WORD_BITS*BIT_CYC cycles.
//  busy = (state != IDLE), registered with state.
//  Widths: cyc = $clog2(BIT_CYC), bit_idx = $clog2(WORD_BITS+1), latch cnt = $clog2(LATCH_CYC+1);
//   all unsigned; no wrap beyond terminal counts.
//  Reset mid-frame: next edge neo_data=0, IDLE; partial frame is abandoned (no latch, no pulses).
//  Elaboration checks: T0H_CYC < T1H_CYC < BIT_CYC, LATCH_CYC >= 1.
// STRUCTURE
//  neopixel_pkg: timing constants for 50MHz, WORD_BITS, state enum type enc_state_t.
//  One sub-module: neo_bit_timer (cycle counter with clear/terminal-count flag), used for
//   the bit slot and reused for the latch interval. Shift reg and FSM stay in this module.
// TESTING
//  1 word 24'hFF0000, last=1: bits 0-7 high 35 cyc, bits 8-23 high 18 cyc, 1512 cyc total, then
//    2500 low; latch_done pulses 4013 cycles after accept edge; busy low same cycle.
//  5 words back-to-back (valid held, last on 5th): no gap, 7560 cycles of bit slots, one latch;
//    word_ready high exactly one cycle at each word end.
//  2 words, second valid arrives 10 cycles late: underrun pulses at end of word 1, LATCH entered,
//    late word accepted only after latch_done (in IDLE).
//  Reset asserted mid-bit 12 of word 3: neo_data=0 next cycle, busy=0, word_ready=1, no latch_done.
//  word_valid toggled randomly during SEND/LATCH: no accept except at word-end cycle or IDLE;
//    waveform bit-exact against reference model.
//  24'h000000 and 24'hFFFFFF words: every slot exactly 63 cycles, high 18 / 35 respectively.

Source files
------------

// File: rtl/neopixel_pkg.sv
// Shared constants and state type for the NeoPixel bit encoder (50 MHz timing).
package neopixel_pkg;

  localparam int unsigned WORD_BITS = 24;
  localparam int unsigned BIT_CYC   = 63;
  localparam int unsigned T0H_CYC   = 18;
  localparam int unsigned T1H_CYC   = 35;
  localparam int unsigned LATCH_CYC = 2500;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } enc_state_t;

endpackage

// File: rtl/neo_bit_timer.sv
// Free-running cycle counter with synchronous clear and a runtime terminal count;
// wraps to zero after the terminal cycle so consecutive intervals need no gap.
module neo_bit_timer #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count_next,
  output logic             at_term
);

  logic [WIDTH-1:0] count_reg;

  assign at_term = (count_reg == term);

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = at_term ? '0 : count_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/neopixel_bit_encoder.sv
// Serialises GRB pixel words onto the single-wire NeoPixel line, MSB first,
// followed by the latch low interval once the frame ends or the source underruns.
module neopixel_bit_encoder #(
  parameter int unsigned WORD_BITS = neopixel_pkg::WORD_BITS,
  parameter int unsigned BIT_CYC   = neopixel_pkg::BIT_CYC,
  parameter int unsigned T0H_CYC   = neopixel_pkg::T0H_CYC,
  parameter int unsigned T1H_CYC   = neopixel_pkg::T1H_CYC,
  parameter int unsigned LATCH_CYC = neopixel_pkg::LATCH_CYC
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] word_data,
  input  logic                 word_valid,
  input  logic                 word_last,
  output logic                 word_ready,
  output logic                 neo_data,
  output logic                 busy,
  output logic                 latch_done,
  output logic                 underrun
);
  import neopixel_pkg::*;

  localparam int unsigned BIT_W = $clog2(BIT_CYC);
  localparam int unsigned LAT_W = $clog2(LATCH_CYC + 1);
  localparam int unsigned CNT_W = (LAT_W > BIT_W) ? LAT_W : BIT_W;
  localparam int unsigned IDX_W = $clog2(WORD_BITS + 1);

  localparam logic [CNT_W-1:0] BIT_TERM   = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] LATCH_TERM = CNT_W'(LATCH_CYC - 1);
  localparam logic [CNT_W-1:0] T0H_VAL    = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] T1H_VAL    = CNT_W'(T1H_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORD_BITS - 1);

  if (!(T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC && LATCH_CYC >= 1)) begin : g_bad_timing
    $error("neopixel_bit_encoder: need T0H_CYC < T1H_CYC < BIT_CYC and LATCH_CYC >= 1");
  end

  enc_state_t           state_reg, state_next;
  logic [WORD_BITS-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
  logic                 last_reg, last_next;
  logic                 neo_data_reg, neo_data_next;
  logic                 busy_reg, busy_next;
  logic                 latch_done_reg, latch_done_next;
  logic                 underrun_reg, underrun_next;

  logic                 tmr_clear, tmr_en, tmr_at_term;
  logic [CNT_W-1:0]     tmr_term_val, tmr_count_next;

  // One counter serves both the bit slot and the latch interval.
  assign tmr_term_val = (state_reg == LATCH) ? LATCH_TERM : BIT_TERM;

  neo_bit_timer #(.WIDTH(CNT_W)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (tmr_clear),
    .enable     (tmr_en),
    .term       (tmr_term_val),
    .count_next (tmr_count_next),
    .at_term    (tmr_at_term)
  );

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    bit_idx_next    = bit_idx_reg;
    last_next       = last_reg;
    latch_done_next = 1'b0;
    underrun_next   = 1'b0;
    word_ready      = 1'b0;
    tmr_clear       = 1'b0;
    tmr_en          = 1'b0;

    unique case (state_reg)
      IDLE: begin
        word_ready = 1'b1;
        tmr_clear  = 1'b1;
        if (word_valid) begin
          shift_next   = word_data;
          bit_idx_next = '0;
          last_next    = word_last;
          state_next   = SEND;
        end
      end
      SEND: begin
        tmr_en = 1'b1;
        if (tmr_at_term) begin
          shift_next   = shift_reg << 1;
          bit_idx_next = bit_idx_reg + IDX_W'(1);
          if (bit_idx_reg == LAST_IDX) begin
            if (last_reg) begin
              state_next = LATCH;
            end else begin
              // Only window mid-frame where the next word can be taken without a gap.
              word_ready = 1'b1;
              if (word_valid) begin
                shift_next   = word_data;
                bit_idx_next = '0;
                last_next    = word_last;
              end else begin
                underrun_next = 1'b1;
                state_next    = LATCH;
              end
            end
          end
        end
      end
      LATCH: begin
        tmr_en = 1'b1;
        if (tmr_at_term) begin
          latch_done_next = 1'b1;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is registered from next-state values so neo_data is glitch-free.
    neo_data_next = (state_next == SEND) &&
                    (tmr_count_next < (shift_next[WORD_BITS-1] ? T1H_VAL : T0H_VAL));
    busy_next     = (state_next != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      bit_idx_reg    <= '0;
      last_reg       <= 1'b0;
      neo_data_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      latch_done_reg <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      bit_idx_reg    <= bit_idx_next;
      last_reg       <= last_next;
      neo_data_reg   <= neo_data_next;
      busy_reg       <= busy_next;
      latch_done_reg <= latch_done_next;
      underrun_reg   <= underrun_next;
    end
  end

  assign neo_data   = neo_data_reg;
  assign busy       = busy_reg;
  assign latch_done = latch_done_reg;
  assign underrun   = underrun_reg;

endmodule
